// File: rtl/input_loader_if.sv
// input_loader_if: pixel stream (pixel_in/pixel_valid/pixel_ready) and RAM write bus (mem_we/mem_addr/mem_wdata); master = host side, slave = loader side
interface input_loader_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] pixel_in;
  logic pixel_valid;
  logic pixel_ready;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  modport master(output pixel_in, pixel_valid, input pixel_ready, mem_we, mem_addr, mem_wdata);
  modport slave(input pixel_in, pixel_valid, output pixel_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/input_loader.sv
// input_loader: streams pixel bytes into RAM at BASE_ADDR.. with done per frame; ports clk, rst, enable, start, bus (slave: pixel stream in, RAM write out), busy, done, count, checksum (byte sum when INPUT_CHECKSUM_EN is defined, else 0)
module input_loader #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int NUM_PIXELS = 160000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic start,
  input_loader_if.slave bus,
  output logic busy,
  output logic done,
  output logic [ADDR_W-1:0] count,
  output logic [15:0] checksum
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_n;
  logic hs, last, launch;
  assign hs = bus.pixel_valid && state == LOAD && enable;
  assign last = count == ADDR_W'(NUM_PIXELS - 1);
  assign launch = enable && start && state != LOAD;
  assign bus.pixel_ready = state == LOAD;
  assign busy = state == LOAD;
  assign done = state == DONE;
  always_comb begin
    state_n = !enable ? IDLE : state == LOAD ? (hs && last ? DONE : LOAD) : start ? LOAD : state;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      count <= '0;
      bus.mem_we <= 1'b0;
    end else begin
      count <= launch ? '0 : hs ? count + 1'b1 : count;
      bus.mem_we <= hs;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
    end else if (hs) begin
      bus.mem_addr <= BASE_ADDR + count;
      bus.mem_wdata <= bus.pixel_in;
    end
  end
`ifdef INPUT_CHECKSUM_EN
  logic [15:0] sum;
  always_ff @(posedge clk) begin
    if (rst || launch) sum <= '0;
    else if (hs) sum <= sum + 16'(bus.pixel_in);
  end
  assign checksum = sum;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_input_loader.sv
// tb_input_loader: scoreboard bench for input_loader with a 4-pixel frame at 18'h27100
module tb_input_loader;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;
  localparam int NP = 4;
  localparam logic [17:0] BASE = 18'h27100;
`ifdef INPUT_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, enable, start, busy, done;
  logic [17:0] count;
  logic [15:0] checksum;
  input_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
  input_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE), .NUM_PIXELS(NP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .bus(bus),
    .busy(busy), .done(done), .count(count), .checksum(checksum)
  );
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  logic [25:0] q[$];
  logic [17:0] addr_exp;
  logic [15:0] cs_exp;
  task automatic tick();
    logic [25:0] e;
    @(posedge clk);
    @(negedge clk);
    if (bus.mem_we) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got addr=%h data=%h want no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        e = q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== e) begin
          errors++;
          $display("FAIL write_data got addr=%h data=%h want addr=%h data=%h", bus.mem_addr, bus.mem_wdata, e[25:8], e[7:0]);
        end
      end
    end else if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL write_missing got no write want addr=%h data=%h", q[0][25:8], q[0][7:0]);
      q.delete();
    end
  endtask
  task automatic send(input logic [7:0] d);
    bus.pixel_valid = 1'b1;
    bus.pixel_in = d;
    q.push_back({addr_exp, d});
    addr_exp++;
    cs_exp += 16'(d);
    tick();
  endtask
  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    addr_exp = BASE;
    cs_exp = '0;
    checks++;
    if (bus.pixel_ready !== 1'b1) begin errors++; $display("FAIL start_ready got=%b want=1", bus.pixel_ready); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL start_done got=%b want=0", done); end
    checks++;
    if (count !== 18'd0) begin errors++; $display("FAIL start_count got=%0d want=0", count); end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    start = 1'b1;
    bus.pixel_valid = 1'b0;
    bus.pixel_in = 8'h00;
    tick();
    tick();
    checks++;
    if (bus.pixel_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", bus.pixel_ready); end
    checks++;
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", bus.mem_we); end
    checks++;
    if (bus.mem_addr !== 18'h0) begin errors++; $display("FAIL reset_addr got=%h want=0", bus.mem_addr); end
    checks++;
    if (bus.mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_wdata got=%h want=0", bus.mem_wdata); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++;
    if (count !== 18'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++;
    if (checksum !== 16'h0) begin errors++; $display("FAIL reset_checksum got=%h want=0", checksum); end
    rst = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle got=%b want=0", busy); end
  endtask
  task automatic test_burst();
    start_frame();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL burst_done got=%b want=1", done); end
    checks++;
    if (bus.pixel_ready !== 1'b0) begin errors++; $display("FAIL burst_ready got=%b want=0", bus.pixel_ready); end
    checks++;
    if (count !== 18'd4) begin errors++; $display("FAIL burst_count got=%0d want=4", count); end
    checks++;
    if (checksum !== (CS_EN ? cs_exp : 16'h0)) begin errors++; $display("FAIL burst_checksum got=%h want=%h", checksum, CS_EN ? cs_exp : 16'h0); end
    bus.pixel_valid = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || count !== 18'd4) begin errors++; $display("FAIL burst_hold got done=%b count=%0d want done=1 count=4", done, count); end
  endtask
  task automatic test_gap();
    start_frame();
    send(8'hA1);
    send(8'hA2);
    bus.pixel_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (count !== 18'd2 || busy !== 1'b1) begin errors++; $display("FAIL gap_mid got count=%0d busy=%b want count=2 busy=1", count, busy); end
    send(8'hA3);
    send(8'hA4);
    bus.pixel_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || count !== 18'd4) begin errors++; $display("FAIL gap_done got done=%b count=%0d want done=1 count=4", done, count); end
  endtask
  task automatic test_abort();
    start_frame();
    send(8'h01);
    send(8'h02);
    bus.pixel_valid = 1'b1;
    bus.pixel_in = 8'h03;
    enable = 1'b0;
    tick();
    checks++;
    if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL abort_we got=%b want=0", bus.mem_we); end
    checks++;
    if (busy !== 1'b0 || bus.pixel_ready !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b ready=%b want 0 0", busy, bus.pixel_ready); end
    checks++;
    if (count !== 18'd0) begin errors++; $display("FAIL abort_count got=%0d want=0", count); end
    enable = 1'b1;
    bus.pixel_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_stay_idle got=%b want=0", busy); end
    start_frame();
    send(8'h55);
    send(8'h66);
    send(8'h77);
    send(8'h88);
    bus.pixel_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL abort_restart_done got=%b want=1", done); end
  endtask
  task automatic test_ignored_start();
    start_frame();
    send(8'h10);
    bus.pixel_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || count !== 18'd1) begin errors++; $display("FAIL midstart got busy=%b count=%0d want busy=1 count=1", busy, count); end
    send(8'h20);
    send(8'h30);
    send(8'h40);
    bus.pixel_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || count !== 18'd4) begin errors++; $display("FAIL midstart_done got done=%b count=%0d want done=1 count=4", done, count); end
  endtask
  task automatic test_checksum();
    start_frame();
    repeat (4) send(8'hFF);
    bus.pixel_valid = 1'b0;
    checks++;
    if (checksum !== (CS_EN ? 16'h03FC : 16'h0000)) begin errors++; $display("FAIL checksum_ff got=%h want=%h", checksum, CS_EN ? 16'h03FC : 16'h0000); end
    enable = 1'b0;
    tick();
    checks++;
    if (checksum !== (CS_EN ? 16'h03FC : 16'h0000)) begin errors++; $display("FAIL checksum_hold got=%h want=%h", checksum, CS_EN ? 16'h03FC : 16'h0000); end
    checks++;
    if (done !== 1'b0 || count !== 18'd0) begin errors++; $display("FAIL disable_clear got done=%b count=%0d want done=0 count=0", done, count); end
    enable = 1'b1;
    tick();
  endtask
  initial begin
    test_reset();
    test_burst();
    test_gap();
    test_abort();
    test_ignored_start();
    test_checksum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/input_loader.md
# input_loader

Streaming image loader that accepts pixel bytes from the host-side GPIO port over a valid/ready handshake and writes them into the shared image RAM at consecutive addresses. It is the write-side counterpart of the output address generator. It fills the input image region before the vector processor runs; the output generator later reads results back. One accepted byte produces one single-cycle RAM write; a `done` flag reports a complete frame.

## Interface
Parameters:
- `ADDR_W`, 18, RAM address width.
- `DATA_W`, 8, pixel width.
- `BASE_ADDR`, 0, first RAM address written.
- `NUM_PIXELS`, 160000, pixels per frame. Constraint: BASE_ADDR + NUM_PIXELS ≤ 2^ADDR_W.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: reset is synchronous and active-high.
- `enable` in 1: block enable. Low forces IDLE and clears the counter.
- `start` in 1: begin a frame. Sampled in IDLE or DONE only.
- `pixel_in` in DATA_W: incoming pixel byte.
- `pixel_valid` in 1: `pixel_in` is valid.
- `pixel_ready` out 1: loader can accept a byte.
- `mem_we` out 1: RAM write strobe, one cycle per byte.
- `mem_addr` out ADDR_W: RAM write address.
- `mem_wdata` out DATA_W: RAM write data.
- `busy` out 1: in LOAD.
- `done` out 1: frame complete, level.
- `count` out ADDR_W: bytes accepted in the current frame.
- `checksum` out 16: running byte sum. See Configuration.

## Operation
- States: IDLE, LOAD, DONE. State is held in a register.
- `pixel_ready` = (state==LOAD). `busy` = (state==LOAD). `done` = (state==DONE).
- IDLE:
  - `start`&&`enable` → LOAD, `count`←0, `checksum`←0.
  - Otherwise stay in IDLE.
- LOAD:
  - A handshake occurs when `pixel_valid`&&`pixel_ready`.
  - On a handshake, next cycle: `mem_we`=1, `mem_addr`=BASE_ADDR+count (old value), `mem_wdata`=`pixel_in`; `count`←count+1.
  - When the accepted byte is number NUM_PIXELS (count was NUM_PIXELS−1), state → DONE on the same edge.
  - `start` in LOAD is ignored.
- DONE:
  - No writes. `count` holds NUM_PIXELS.
  - `start`&&`enable` → LOAD with `count`←0, `checksum`←0.
- `enable` low in any state → IDLE next edge. `count`←0, `mem_we`←0; `checksum` holds its value. `enable` has priority over `start` and over a handshake on the same cycle; that byte is not written.
- `rst` has the same effect as `enable` low, and also clears `checksum`, `mem_addr` and `mem_wdata`.
- Address arithmetic: ADDR_W-bit add, no wrap. The parameter constraint guarantees the add fits. Addresses are strictly contiguous, independent of gaps in `pixel_valid`.
- `mem_addr` and `mem_wdata` hold their last written values while `mem_we`=0.
- The RAM accepts every write in one cycle. There is no write back-pressure.

## Timing
- Reset values: `pixel_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `count`=0, `checksum`=0.
- `start` at edge N → `pixel_ready`=1 from cycle N+1.
- Handshake at edge N → `mem_we` pulse during cycle N+1. Latency is 1 cycle.
- Throughput: one byte per cycle with `pixel_valid` held high.
- The last handshake at edge N gives `pixel_ready`=0 and `done`=1 in cycle N+1, coincident with the last `mem_we`.
- `done` stays high until the next `start`, `enable` low, or `rst`.

## Configuration
- `INPUT_CHECKSUM_EN` defined:
  - `checksum` accumulates a mod-2^16 sum of accepted bytes (zero-extended).
  - It updates on the handshake edge, so it is valid together with `done`.
- `INPUT_CHECKSUM_EN` not defined:
  - `checksum` is tied to 16'h0000.
  - No accumulator logic is synthesized.

## Test plan
- Reset: assert `rst` for 2 cycles with `start`=1 → all outputs at their reset values, state IDLE, no `mem_we`.
- Burst (BASE_ADDR=18'h27100, NUM_PIXELS=4): `start`, then bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles → `mem_we` for 4 cycles at 0x27100–0x27103 with matching data; `done`=1 with the last write; `pixel_ready`=0 afterwards; `count`=4.
- Gapped valid: same frame with `pixel_valid` low for 3 cycles between bytes 2 and 3 → no `mem_we` during the gap; addresses stay contiguous 0x27100–0x27103.
- Abort: drop `enable` on the cycle of the 3rd handshake → no 3rd write; IDLE with `count`=0 next cycle. Restart writes the first byte to 0x27100.
- Restart/ignored start: pulse `start` mid-LOAD → no effect. `start` in DONE → new frame from BASE_ADDR, `done` cleared next cycle.
- Checksum: 4 bytes of 0xFF → `checksum`=16'h03FC at `done` with `INPUT_CHECKSUM_EN` defined; 16'h0000 without it.
